// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, FSM state type and byte-lane decode
//
// Purpose: common definitions for the AHB SRAM slave and its bench.
// Contents:
//   HTRANS_*  transfer type encodings
//   HSIZE_*   transfer size encodings
//   HRESP_*   response encodings
//   state_e   data-phase FSM states
//   byte_lanes() maps HSIZE/HADDR[1:0] to a 4-bit byte-lane mask
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Misaligned halfwords still pick a lane pair from bit 1, and anything
  // wider than a halfword touches the whole word.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << a;
      HSIZE_HALF: lanes = a[1] ? 4'b1100 : 4'b0011;
      default:    lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite bus bundle between a master and the SRAM slave
//
// Purpose: groups the address-phase, data-phase and response signals.
// Signals:
//   HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0],
//   HPROT[3:0], HMASTLOCK, HREADY, HWDATA[31:0]   master -> slave
//   HRDATA[31:0], HREADYOUT, HRESP[1:0]            slave -> master
// Modports: master, slave.
interface ahb_sram_slave_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HREADY, HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_sram_bytelane_mem.sv
// rtl/ahb_sram_bytelane_mem.sv - 32-bit synchronous RAM with byte write enables
//
// Purpose: 2^ADDR_W x 32 storage array, registered read, per-byte writes.
// Ports:
//   clk_i           clock
//   we_i[3:0]       byte write enables
//   waddr_i         write word address
//   wdata_i[31:0]   write data
//   re_i            read enable (read register updates only when set)
//   raddr_i         read word address
//   rdata_o[31:0]   registered read data
module ahb_sram_bytelane_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(1 << ADDR_W)-1];
  logic [31:0] rdata_q;

  // Read-before-write: a read and a write to the same word on one edge
  // return the old word; the slave merges the new lanes itself.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with wait states, ERROR response and RAW forwarding
//
// Purpose: pipelined AHB slave in front of a byte-lane SRAM.
// Parameters:
//   RAM_LOG2     log2 of depth in 32-bit words
//   WAIT_STATES  HREADYOUT-low cycles at the start of each OKAY data phase (0..15)
//   ERR_EN       1: out-of-range/misaligned accesses get ERROR; 0: address wraps
// Ports:
//   HCLK    bus clock
//   HRESET  asynchronous active-high reset
//   bus     ahb_sram_slave_if.slave (address/data/response signals)
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int RAM_LOG2    = 12,
  parameter int WAIT_STATES = 0,
  parameter bit ERR_EN      = 1'b1
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_sram_slave_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [RAM_LOG2-1:0] addr_q, addr_d;
  logic [3:0]          lanes_q, lanes_d;
  logic                write_q, write_d;
  logic                hready_q, hready_d;
  logic [1:0]          hresp_q, hresp_d;
  logic [3:0]          fwd_mask_q, fwd_mask_d;
  logic [31:0]         fwd_data_q, fwd_data_d;
  logic [31:0]         hrdata_q, hrdata_d;

  logic                can_accept;
  logic                accept;
  logic [RAM_LOG2-1:0] a_word;
  logic [3:0]          a_lanes;
  logic                a_err;
  logic                commit;
  logic                read_phase;
  logic                mem_re;
  logic [3:0]          mem_we;
  logic [31:0]         mem_rdata;
  logic [31:0]         merged;

  wire unused_bus = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  // A new address phase is only taken when no data phase of ours is stalling.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ACCESS) || (state_q == ST_ERR2);
  assign accept     = can_accept && bus.HSEL && bus.HREADY && bus.HTRANS[1];

  always_comb begin
    a_word  = bus.HADDR[RAM_LOG2+1:2];
    a_lanes = byte_lanes(bus.HSIZE, bus.HADDR[1:0]);
    a_err   = 1'b0;
    if (ERR_EN) begin
      a_err = (|bus.HADDR[31:RAM_LOG2+2])
            || (bus.HSIZE > HSIZE_WORD)
            || (bus.HSIZE == HSIZE_HALF && bus.HADDR[0])
            || (bus.HSIZE == HSIZE_WORD && (|bus.HADDR[1:0]));
    end
  end

  // The write data phase completes on the edge that ends ACCESS.
  assign commit     = (state_q == ST_ACCESS) && write_q;
  assign read_phase = (state_q == ST_ACCESS) && !write_q;
  assign mem_we     = commit ? lanes_q : 4'b0000;
  assign mem_re     = accept && !bus.HWRITE && !a_err;

  ahb_sram_bytelane_mem #(
    .ADDR_W (RAM_LOG2)
  ) u_mem (
    .clk_i   (HCLK),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (bus.HWDATA),
    .re_i    (mem_re),
    .raddr_i (a_word),
    .rdata_o (mem_rdata)
  );

  // Lanes committed on the read's accepting edge override the stale RAM word.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : mem_rdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    lanes_d    = lanes_q;
    write_d    = write_q;
    hready_d   = hready_q;
    hresp_d    = hresp_q;
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    hrdata_d   = read_phase ? merged : hrdata_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_ACCESS;
          hready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
      end
      default: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        if (accept) begin
          addr_d     = a_word;
          lanes_d    = a_lanes;
          write_d    = bus.HWRITE;
          fwd_mask_d = (commit && addr_q == a_word) ? lanes_q : 4'b0000;
          fwd_data_d = bus.HWDATA;
          if (a_err) begin
            state_d  = ST_ERR1;
            hready_d = 1'b0;
            hresp_d  = HRESP_ERROR;
          end else if (WAIT_STATES > 0) begin
            state_d  = ST_WAIT;
            hready_d = 1'b0;
            cnt_d    = WAIT_LOAD;
          end else begin
            state_d  = ST_ACCESS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      lanes_q    <= 4'b0000;
      write_q    <= 1'b0;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
      fwd_mask_q <= 4'b0000;
      fwd_data_q <= 32'h0;
      hrdata_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      lanes_q    <= lanes_d;
      write_q    <= write_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
      hrdata_q   <= hrdata_d;
    end
  end

  assign bus.HREADYOUT = hready_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = read_phase ? merged : hrdata_q;

endmodule
